// File: rtl/axi_lite_write_slave.sv
// AXI-lite write-path slave: captures AW and W independently, decodes the word address
// against an NREGS-deep register window, issues one register write and returns B.
module axi_lite_write_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NREGS      = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [ADDR_WIDTH-1:0]      awaddr,
    input  logic                       wvalid,
    output logic                       wready,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    output logic                       bvalid,
    input  logic                       bready,
    output logic [1:0]                 bresp,
    output logic                       reg_wen,
    output logic [$clog2(NREGS)-1:0]   reg_windex,
    output logic [DATA_WIDTH-1:0]      reg_wdata,
    output logic [DATA_WIDTH/8-1:0]    reg_wstrb,
    input  logic                       reg_wready,
    input  logic                       reg_werr
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(NREGS);
    localparam logic [ADDR_WIDTH:0] WINDOW_BYTES = (ADDR_WIDTH+1)'(NREGS * STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    awready_q, wready_q, bvalid_q, reg_wen_q;
    logic [1:0]              bresp_q;
    logic [IDX_W-1:0]        reg_windex_q;
    logic [DATA_WIDTH-1:0]   reg_wdata_q;
    logic [STRB_W-1:0]       reg_wstrb_q;
    logic                    aw_have_q, w_have_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       wstrb_q;

    logic                    aw_hs, w_hs;
    logic                    aw_have_d, w_have_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [STRB_W-1:0]       wstrb_d;
    logic                    in_range;

    // Decode looks at this cycle's beat when it arrives, so a same-cycle AW+W
    // reaches WRITE/RESP one cycle after the handshake.
    always_comb begin
        aw_hs     = awvalid && awready_q;
        w_hs      = wvalid && wready_q;
        aw_have_d = aw_have_q || aw_hs;
        w_have_d  = w_have_q || w_hs;
        addr_d    = aw_hs ? awaddr : addr_q;
        wdata_d   = w_hs ? wdata : wdata_q;
        wstrb_d   = w_hs ? wstrb : wstrb_q;
        in_range  = {1'b0, addr_d} < WINDOW_BYTES;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            reg_wen_q    <= 1'b0;
            reg_windex_q <= '0;
            reg_wdata_q  <= '0;
            reg_wstrb_q  <= '0;
            aw_have_q    <= 1'b0;
            w_have_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    aw_have_q <= aw_have_d;
                    w_have_q  <= w_have_d;
                    addr_q    <= addr_d;
                    wdata_q   <= wdata_d;
                    wstrb_q   <= wstrb_d;
                    if (aw_have_d && w_have_d) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        if (in_range) begin
                            state_q      <= S_WRITE;
                            reg_wen_q    <= 1'b1;
                            reg_windex_q <= addr_d[LSB +: IDX_W];
                            reg_wdata_q  <= wdata_d;
                            reg_wstrb_q  <= wstrb_d;
                        end else begin
                            state_q  <= S_RESP;
                            bvalid_q <= 1'b1;
                            bresp_q  <= RESP_SLVERR;
                        end
                    end else begin
                        awready_q <= !aw_have_d;
                        wready_q  <= !w_have_d;
                    end
                end
                S_WRITE: begin
                    if (reg_wready) begin
                        state_q   <= S_RESP;
                        reg_wen_q <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= reg_werr ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                S_RESP: begin
                    if (bready) begin
                        state_q   <= S_IDLE;
                        bvalid_q  <= 1'b0;
                        aw_have_q <= 1'b0;
                        w_have_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign awready    = awready_q;
    assign wready     = wready_q;
    assign bvalid     = bvalid_q;
    assign bresp      = bresp_q;
    assign reg_wen    = reg_wen_q;
    assign reg_windex = reg_windex_q;
    assign reg_wdata  = reg_wdata_q;
    assign reg_wstrb  = reg_wstrb_q;

endmodule

// File: tb/tb_axi_lite_write_slave.sv
// Randomized bench for axi_lite_write_slave: each transaction is predicted from the
// address-window rules and checked cycle by cycle for handshakes, latency and response.
module tb_axi_lite_write_slave;

    localparam int unsigned NREGS = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        reg_wen;
    logic [3:0]  reg_windex;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_wready, reg_werr;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clock = ~clock;

    axi_lite_write_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NREGS     (NREGS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .bvalid    (bvalid),
        .bready    (bready),
        .bresp     (bresp),
        .reg_wen   (reg_wen),
        .reg_windex(reg_windex),
        .reg_wdata (reg_wdata),
        .reg_wstrb (reg_wstrb),
        .reg_wready(reg_wready),
        .reg_werr  (reg_werr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_awready"}, 64'(awready), 64'(0));
        check({tag, "_wready"},  64'(wready),  64'(0));
        check({tag, "_bvalid"},  64'(bvalid),  64'(0));
        check({tag, "_bresp"},   64'(bresp),   64'(0));
        check({tag, "_wen"},     64'(reg_wen), 64'(0));
        check({tag, "_windex"},  64'(reg_windex), 64'(0));
        check({tag, "_wdata"},   64'(reg_wdata),  64'(0));
        check({tag, "_wstrb"},   64'(reg_wstrb),  64'(0));
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int unsigned aw_dly, input int unsigned w_dly,
                           input int unsigned stall, input bit werr, input int unsigned bstall);
        bit          in_range, aw_done, w_done, b_done;
        logic [3:0]  exp_idx;
        logic [1:0]  exp_bresp;
        int unsigned cyc, t_aw, t_w, t_hs, aw_cnt, w_cnt, wen_cnt, whs_cnt, bv_cnt;
        int          first_wen, first_bv;

        in_range  = addr < 32'(NREGS * 4);
        exp_idx   = 4'((addr / 4) % NREGS);
        exp_bresp = (!in_range || werr) ? 2'b10 : 2'b00;
        aw_done = 0; w_done = 0; b_done = 0;
        cyc = 0; t_aw = 0; t_w = 0; aw_cnt = 0; w_cnt = 0;
        wen_cnt = 0; whs_cnt = 0; bv_cnt = 0;
        first_wen = -1; first_bv = -1;

        while (!b_done && cyc < 200) begin
            // After its beat is taken, a channel keeps offering junk that must be refused.
            awvalid    = aw_done ? ($urandom_range(0, 1) == 1) : (cyc >= aw_dly);
            awaddr     = aw_done ? $urandom : addr;
            wvalid     = w_done ? ($urandom_range(0, 1) == 1) : (cyc >= w_dly);
            wdata      = w_done ? $urandom : data;
            wstrb      = w_done ? 4'($urandom) : strb;
            reg_wready = (wen_cnt >= stall);
            reg_werr   = reg_wready ? werr : ($urandom_range(0, 1) == 1);
            bready     = (bv_cnt >= bstall);
            @(negedge clock);
            check(aw_done ? "awready_closed" : "awready_open", 64'(awready), 64'(!aw_done));
            check(w_done ? "wready_closed" : "wready_open", 64'(wready), 64'(!w_done));
            if (!(aw_done && w_done))
                check("bvalid_early", 64'(bvalid), 64'(0));
            if (awvalid && awready) begin aw_cnt++; aw_done = 1; t_aw = cyc; end
            if (wvalid && wready)   begin w_cnt++;  w_done = 1;  t_w = cyc;  end
            if (reg_wen) begin
                if (first_wen < 0) first_wen = int'(cyc);
                check("reg_windex", 64'(reg_windex), 64'(exp_idx));
                check("reg_wdata",  64'(reg_wdata),  64'(data));
                check("reg_wstrb",  64'(reg_wstrb),  64'(strb));
                if (reg_wready) whs_cnt++;
                wen_cnt++;
            end
            if (bvalid) begin
                if (first_bv < 0) first_bv = int'(cyc);
                check("bresp", 64'(bresp), 64'(exp_bresp));
                if (bready) b_done = 1;
                bv_cnt++;
            end
            @(posedge clock); #1;
            cyc++;
        end

        check("b_handshake", 64'(b_done), 64'(1));
        check("aw_beats", 64'(aw_cnt), 64'(1));
        check("w_beats",  64'(w_cnt),  64'(1));
        t_hs = (t_aw > t_w) ? t_aw : t_w;
        if (in_range) begin
            check("wen_latency", 64'(first_wen), 64'(t_hs + 1));
            check("wen_cycles",  64'(wen_cnt),   64'(stall + 1));
            check("reg_handshakes", 64'(whs_cnt), 64'(1));
            check("b_latency",   64'(first_bv),  64'(t_hs + 2 + stall));
        end else begin
            check("wen_cycles_oor", 64'(wen_cnt), 64'(0));
            check("b_latency_oor", 64'(first_bv), 64'(t_hs + 1));
        end
        check("bvalid_cycles", 64'(bv_cnt), 64'(bstall + 1));

        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        @(negedge clock);
        check("post_awready", 64'(awready), 64'(1));
        check("post_wready",  64'(wready),  64'(1));
        check("post_bvalid",  64'(bvalid),  64'(0));
        check("post_wen",     64'(reg_wen), 64'(0));
        @(posedge clock); #1;
    endtask

    task automatic random_txn();
        logic [31:0] addr;
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7)       addr = 32'($urandom_range(0, 63));
        else if (r == 7) addr = 32'($urandom_range(64, 127));
        else             addr = $urandom | 32'h0000_0100;
        run_txn(addr, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), ($urandom_range(0, 1) == 1), $urandom_range(0, 3));
    endtask

    initial begin
        reset = 1'b1;
        awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0;
        bready = 1'b0; reg_wready = 1'b0; reg_werr = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_values("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("first_cycle_awready", 64'(awready), 64'(0));
        @(posedge clock); #1;

        run_txn(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0, 0);
        run_txn(32'h3C, 32'h12345678, 4'hF, 3, 0, 0, 1'b0, 0);
        run_txn(32'h40, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 1'b0, 0);
        run_txn(32'h1000_0008, 32'h0BADF00D, 4'h3, 1, 0, 0, 1'b0, 0);
        run_txn(32'h14, 32'hCAFEF00D, 4'h5, 0, 0, 3, 1'b1, 0);
        run_txn(32'h3F, 32'h0000_0000, 4'h0, 0, 2, 0, 1'b0, 0);
        run_txn(32'h20, 32'h11112222, 4'hC, 0, 0, 0, 1'b0, 5);
        run_txn(32'h24, 32'h33334444, 4'h9, 0, 0, 0, 1'b0, 0);

        // Reset while the register write is pending: no B must follow.
        awaddr = 32'h10; awvalid = 1'b1; wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1'b1;
        reg_wready = 1'b0; bready = 1'b1;
        @(posedge clock); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clock);
        check("rst_pre_wen", 64'(reg_wen), 64'(1));
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_reset_values("midrst");
        @(posedge clock); #1;
        @(negedge clock);
        check("midrst_awready", 64'(awready), 64'(1));
        check("midrst_wready",  64'(wready),  64'(1));
        check("midrst_no_b",    64'(bvalid),  64'(0));
        @(posedge clock); #1;
        run_txn(32'h04, 32'h600DD00D, 4'hF, 0, 0, 0, 1'b0, 0);

        for (int i = 0; i < 60; i++) random_txn();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
